serial_parity_rx: RTL and testbench

Serial frame receiver with XOR parity check: the receiving end of the team's XOR-based even/odd parity link. Deserialises one frame (start bit, DATA_W data bits LSB first, one parity bit, stop bit) from a single idle-high line, sampled on a bit-rate strobe. Presents the word with parity and framing status as a one-cycle valid pulse to downstream logic.

---
 rtl/serial_parity_rx_pkg.sv | 15 +
 rtl/serial_parity_rx_parity_xor.sv | 11 +
 rtl/serial_parity_rx.sv | 124 ++++++++++++
 tb/tb_serial_parity_rx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/serial_parity_rx_pkg.sv
// Shared definitions for the XOR parity serial link (receiver and transmitter).
// State encodings and parity-mode constants must match on both ends.
package serial_parity_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/serial_parity_rx_parity_xor.sv
// XOR reduction of a W-bit word; shared by the receiver check and transmitter generation.
module parity_xor #(
    parameter int W = 8
) (
    input  logic [W-1:0] din,
    output logic         parity
);

    assign parity = ^din;

endmodule

// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB first, parity, stop; sampled on bit_tick.
// Delivers the word with parity/framing status as a one-cycle valid pulse; results held until next frame.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | line idle, waiting for a ticked rxd=0 start bit
//  ST_DATA   | shifting DATA_W data bits into the MSB of the shift register
//  ST_PARITY | capturing the received parity bit
//  ST_STOP   | sampling stop bit, publishing data/parity_err/frame_err/valid
module serial_parity_rx
    import serial_parity_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_tick,
    input  logic              rxd,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic PAR_MODE = (ODD_PARITY == 1'b1) ? PARITY_ODD : PARITY_EVEN;

    rx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               par_bit_q, par_bit_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;
    logic               busy_q, busy_d;
    logic               word_parity;

    parity_xor #(
        .W (DATA_W)
    ) u_parity_xor (
        .din    (shift_q),
        .parity (word_parity)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;

        if (bit_tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!rxd) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end
                end
                ST_DATA: begin
                    // Line is LSB first: each new bit enters at the top and walks down.
                    shift_d             = shift_q >> 1;
                    shift_d[DATA_W-1]   = rxd;
                    cnt_d               = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_bit_d = rxd;
                    state_d   = ST_STOP;
                end
                ST_STOP: begin
                    data_d  = shift_q;
                    perr_d  = word_parity ^ par_bit_q ^ PAR_MODE;
                    ferr_d  = ~rxd;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_serial_parity_rx.sv
// Bench for serial_parity_rx: even and odd instances on a shared line, checked each cycle
// against a frame-level model of what the sender put on the wire.
module tb_serial_parity_rx;

    localparam int EV_NONE  = 0;
    localparam int EV_START = 1;
    localparam int EV_STOP  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_tick = 1'b0;
    logic       rxd = 1'b1;

    logic [7:0] data_e, data_o;
    logic       valid_e, valid_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;

    logic [7:0] exp_data = '0;
    logic       exp_valid = 1'b0;
    logic       exp_perr_e = 1'b0;
    logic       exp_perr_o = 1'b0;
    logic       exp_ferr = 1'b0;
    logic       exp_busy = 1'b0;

    logic [7:0] cur_data;
    logic       cur_pbit, cur_stop;

    int  errors = 0;
    int  checks = 0;
    bit  chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b0)) dut_even (
        .clk(clk), .rst_n(rst_n), .bit_tick(bit_tick), .rxd(rxd),
        .data(data_e), .valid(valid_e), .parity_err(perr_e),
        .frame_err(ferr_e), .busy(busy_e)
    );

    serial_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .bit_tick(bit_tick), .rxd(rxd),
        .data(data_o), .valid(valid_o), .parity_err(perr_o),
        .frame_err(ferr_o), .busy(busy_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid_even", valid_e, exp_valid);
            chk("valid_odd",  valid_o, exp_valid);
            chk("busy_even",  busy_e,  exp_busy);
            chk("busy_odd",   busy_o,  exp_busy);
            chk("data_even",  data_e,  exp_data);
            chk("data_odd",   data_o,  exp_data);
            chk("perr_even",  perr_e,  exp_perr_e);
            chk("perr_odd",   perr_o,  exp_perr_o);
            chk("ferr_even",  ferr_e,  exp_ferr);
            chk("ferr_odd",   ferr_o,  exp_ferr);
        end
    end

    // One clock with the given line values; afterwards the model reflects that edge.
    task automatic step(input logic t, input logic r, input int ev);
        bit_tick = t;
        rxd      = r;
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        if (ev == EV_START) exp_busy = 1'b1;
        if (ev == EV_STOP) begin
            exp_busy   = 1'b0;
            exp_valid  = 1'b1;
            exp_data   = cur_data;
            exp_perr_e = (^cur_data) ^ cur_pbit;
            exp_perr_o = ~((^cur_data) ^ cur_pbit);
            exp_ferr   = ~cur_stop;
        end
    endtask

    task automatic send_bit(input logic r, input int ev, input int gap, input bit noise);
        for (int i = 1; i < gap; i++)
            step(1'b0, noise ? logic'($urandom_range(0, 1)) : r, EV_NONE);
        step(1'b1, r, ev);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb,
                              input int gap, input bit noise);
        cur_data = d;
        cur_pbit = pb;
        cur_stop = sb;
        send_bit(1'b0, EV_START, gap, noise);
        for (int i = 0; i < 8; i++) send_bit(d[i], EV_NONE, gap, noise);
        send_bit(pb, EV_NONE, gap, noise);
        send_bit(sb, EV_STOP, gap, noise);
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        #1;
        exp_data   = '0;
        exp_valid  = 1'b0;
        exp_perr_e = 1'b0;
        exp_perr_o = 1'b0;
        exp_ferr   = 1'b0;
        exp_busy   = 1'b0;
        repeat (3) step(1'b0, 1'b1, EV_NONE);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] rd;
        logic       rpb, rsb;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_data",  data_e,  32'h0);
        chk("rst_valid", valid_e, 32'h0);
        chk("rst_busy",  busy_o,  32'h0);
        chk("rst_perr",  perr_o,  32'h0);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        repeat (2) step(1'b0, 1'b1, EV_NONE);

        // 0xA5, even parity bit 0, good stop
        send_frame(8'hA5, 1'b0, 1'b1, 4, 1'b0);
        chk("lit_a5_valid", valid_e, 32'h1);
        chk("lit_a5_data",  data_e,  32'hA5);
        chk("lit_a5_perr",  perr_e,  32'h0);
        chk("lit_a5_ferr",  ferr_e,  32'h0);

        // 0x01 with parity bit 0: wrong for even, right for odd
        send_frame(8'h01, 1'b0, 1'b1, 4, 1'b0);
        chk("lit_01_data",     data_e, 32'h01);
        chk("lit_01_perr_even", perr_e, 32'h1);
        chk("lit_01_perr_odd",  perr_o, 32'h0);

        // 0x3C with bad stop, then 0x55 back-to-back
        send_frame(8'h3C, 1'b0, 1'b0, 4, 1'b0);
        chk("lit_3c_data", data_e, 32'h3C);
        chk("lit_3c_ferr", ferr_e, 32'h1);
        chk("lit_3c_perr", perr_e, 32'h0);
        send_frame(8'h55, 1'b0, 1'b1, 4, 1'b0);
        chk("lit_55_data", data_e, 32'h55);
        chk("lit_55_ferr", ferr_e, 32'h0);
        chk("lit_55_perr", perr_e, 32'h0);

        // abort after 4 data bits
        cur_data = 8'hFF;
        send_bit(1'b0, EV_START, 4, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, EV_NONE, 4, 1'b0);
        apply_reset();
        chk("lit_abort_data", data_e, 32'h0);
        chk("lit_abort_busy", busy_e, 32'h0);
        send_frame(8'hF0, 1'b0, 1'b1, 4, 1'b0);
        chk("lit_f0_data",  data_e,  32'hF0);
        chk("lit_f0_valid", valid_e, 32'h1);

        // rxd noise on non-tick cycles
        send_frame(8'h96, 1'b0, 1'b1, 4, 1'b1);
        chk("lit_96_data", data_o, 32'h96);
        chk("lit_96_perr", perr_e, 32'h0);
        chk("lit_96_ferr", ferr_o, 32'h0);

        // bit_tick held high, back-to-back frames
        send_frame(8'hC3, 1'b0, 1'b1, 1, 1'b0);
        send_frame(8'h7E, 1'b1, 1'b1, 1, 1'b0);
        chk("lit_7e_data", data_e, 32'h7E);
        chk("lit_7e_perr", perr_e, 32'h1);

        // idle line
        repeat (50) step(1'b1, 1'b1, EV_NONE);
        chk("lit_idle_busy", busy_e, 32'h0);

        for (int n = 0; n < 40; n++) begin
            rd  = 8'($urandom_range(0, 255));
            rpb = (^rd) ^ ($urandom_range(0, 3) == 0);
            rsb = ($urandom_range(0, 4) != 0);
            send_frame(rd, rpb, rsb, int'($urandom_range(1, 5)), bit'($urandom_range(0, 1)));
        end
        repeat (10) step(1'b1, 1'b1, EV_NONE);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
